dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port, word-addressed data memory between two requesters: the CPU MEM stage (port c_*) and a loader/DMA engine (port d_*).
- Arbitrates with fixed CPU priority plus a starvation guard for the loader.
- Drives the memory's enable, write-enable, address and write data, then routes the 1-cycle-latency read data back to whichever requester owns it.
- Sits between the MEM pipeline stage and the data memory; the loader side connects to the test/boot loader.

Parameters:
- ADDR_W, 8, word-index width; memory depth = 2**ADDR_W words.
- STARVE_LIMIT, 4, number of consecutive cycles the loader may wait before it is forced to win one grant (range 1..15).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- c_req  in  1  CPU access request; held until c_gnt.
- c_we  in  1  1 = store, 0 = load.
- c_addr  in  32  CPU byte address.
- c_wdata  in  32  CPU store data.
- c_gnt  out  1  CPU request accepted this cycle.
- c_rvalid  out  1  CPU load data or error valid.
- c_rdata  out  32  CPU load data.
- c_err  out  1  misaligned access reported, valid with c_rvalid.
- d_req, d_we, d_addr[31:0], d_wdata[31:0]  in  loader request; same meaning as the c_* inputs.
- d_gnt, d_rvalid, d_rdata[31:0], d_err  out  loader responses; same meaning as the c_* outputs.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word index, taken as addr[ADDR_W+1:2].
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid the cycle after a read strobe.

Behaviour:
- Reset, asynchronous: all *_gnt, *_rvalid, *_err, mem_en and mem_we are 0; *_rdata and mem_wdata are 0; starve_cnt = 0; rsp_owner = CPU; rsp_pend = 0. Reset asserted mid-access drops any pending response; no rvalid is issued for it.
- Grant is combinational from the current request inputs and registered state. At most one grant per cycle, so one access per cycle with full back-to-back throughput.
- Priority:
  - If only one requester is active, it wins.
  - If both are active, CPU wins unless starve_cnt == STARVE_LIMIT, in which case the loader wins.
- starve_cnt:
  - Increments when d_req=1 and the loader is not granted, saturating at STARVE_LIMIT.
  - Clears to 0 on d_gnt or when d_req=0.
- A granted aligned access drives mem_en=1, mem_we=req_we, mem_addr and mem_wdata in the same cycle as the grant.
  - Store: complete at that edge; no rvalid is returned.
  - Load: rsp_pend=1 and rsp_owner=winner are registered. Next cycle, the owner sees rvalid=1, rdata=mem_rdata, err=0.
- A granted misaligned access (addr[1:0] != 0), load or store:
  - Grant is still given, but mem_en stays 0 and memory is untouched.
  - Next cycle, the owner sees rvalid=1, err=1, rdata=0.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo the memory depth.
- Response pipeline: rvalid is a one-cycle pulse. A new grant in the response cycle is legal; responses return strictly in grant order, one per cycle.
- Read-after-write to the same word in consecutive cycles returns the new data; this follows from memory write-then-read ordering, and the arbiter does no forwarding.
- Requesters must hold req/addr/we/wdata stable until gnt. A req dropped before gnt is a legal withdrawal.
- When no grant is given: mem_en=0, mem_we=0, and mem_addr/mem_wdata hold their last values.

Decomposition:
- Shared package dmem_pkg:
  - OWNER_CPU=1'b0 and OWNER_DMA=1'b1.
  - DMEM_ADDR_W default constant.
  - WORD_W=32.
  - A function returning the word index and misalignment flag from a byte address.
- One natural sub-module: dmem_arb_prio. It contains the starvation counter plus the priority select, with inputs c_req, d_req and outputs c_gnt, d_gnt.
- The response pipeline and memory drive stay in the top module.

Test Plan:
- CPU store then load: c_req with we=1, addr=0x10, wdata=0xDEADBEEF; then load addr=0x10 -> cycle 1: mem_en=1, mem_we=1, mem_addr=4; cycle 2 grant; cycle 3 c_rvalid=1, c_rdata=0xDEADBEEF, c_err=0.
- Contention with STARVE_LIMIT=4: c_req and d_req held high with continuous CPU loads -> c_gnt for 4 cycles, d_gnt on the 5th, then CPU regains the grant; starve_cnt resets to 0 after d_gnt.
- Misaligned access: c_req load addr=0x13 -> c_gnt=1, mem_en=0; next cycle c_rvalid=1, c_err=1, c_rdata=0; memory word 4 unchanged.
- Back-to-back mixed owners: CPU load addr=0x0, then loader load addr=0x4 in consecutive cycles -> c_rvalid on cycle 2 and d_rvalid on cycle 3, each with its own word; no cross-routing.
- Wrap-around: loader store addr=0x400 with ADDR_W=8, wdata=0x1234 -> mem_addr=0; a later CPU load addr=0x0 returns 0x1234.
- Reset mid-load: grant a CPU load, assert reset before the next edge -> c_rvalid stays 0 and all outputs are 0; after release, the first new load completes normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter: owner encoding,
// default widths and byte-address decoding.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 8;
    localparam int WORD_W      = 32;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    typedef struct packed {
        logic [29:0] word_idx;
        logic        misaligned;
    } addr_dec_t;

    // Full 30-bit word index; callers keep only the low ADDR_W bits, which
    // makes out-of-range addresses wrap modulo the memory depth.
    function automatic addr_dec_t decode_addr(input logic [31:0] byte_addr);
        addr_dec_t r;
        r.word_idx   = byte_addr[31:2];
        r.misaligned = |byte_addr[1:0];
        return r;
    endfunction

endpackage

// File: rtl/dmem_arb_prio.sv
// Two-way fixed-priority select (CPU first) with a saturating starvation
// counter that forces one loader grant after STARVE_LIMIT waiting cycles.
module dmem_arb_prio #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic c_req,
    input  logic d_req,
    output logic c_gnt,
    output logic d_gnt
);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;
    logic       limit_hit;

    assign limit_hit = (starve_cnt_q == 4'(STARVE_LIMIT));

    // Grants are masked while reset is held so the memory sees no strobe.
    always_comb begin
        d_gnt = !reset && d_req && (!c_req || limit_hit);
        c_gnt = !reset && c_req && !d_gnt;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!d_req || d_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (!limit_hit) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port word memory between the CPU MEM stage and the
// loader; drives the memory and routes 1-cycle read data to its owner.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [31:0]       c_addr,
    input  logic [WORD_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [WORD_W-1:0] c_rdata,
    output logic              c_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    logic              any_gnt;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [WORD_W-1:0] sel_wdata;
    addr_dec_t         sel_dec;
    logic              unused_addr_bits;

    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [WORD_W-1:0] wdata_q,     wdata_d;
    logic              rsp_pend_q,  rsp_pend_d;
    logic              rsp_owner_q, rsp_owner_d;
    logic              rsp_err_q,   rsp_err_d;

    dmem_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk  (clk),
        .reset(reset),
        .c_req(c_req),
        .d_req(d_req),
        .c_gnt(c_gnt),
        .d_gnt(d_gnt)
    );

    assign any_gnt          = c_gnt | d_gnt;
    assign sel_dec          = decode_addr(sel_addr);
    assign unused_addr_bits = ^sel_dec.word_idx[29:ADDR_W];

    always_comb begin
        sel_we    = d_gnt ? d_we    : c_we;
        sel_addr  = d_gnt ? d_addr  : c_addr;
        sel_wdata = d_gnt ? d_wdata : c_wdata;
    end

    // Address and data follow the winner in the grant cycle and hold otherwise.
    always_comb begin
        mem_en      = any_gnt && !sel_dec.misaligned;
        mem_we      = mem_en && sel_we;
        addr_d      = any_gnt ? sel_dec.word_idx[ADDR_W-1:0] : addr_q;
        wdata_d     = any_gnt ? sel_wdata : wdata_q;
        mem_addr    = addr_d;
        mem_wdata   = wdata_d;
        rsp_pend_d  = any_gnt && (!sel_we || sel_dec.misaligned);
        rsp_err_d   = any_gnt && sel_dec.misaligned;
        rsp_owner_d = any_gnt ? (d_gnt ? OWNER_DMA : OWNER_CPU) : rsp_owner_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_pend_q  <= 1'b0;
            rsp_owner_q <= OWNER_CPU;
            rsp_err_q   <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_pend_q  <= rsp_pend_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Read data arrives combinationally from the memory in the response cycle.
    always_comb begin
        c_rvalid = rsp_pend_q && (rsp_owner_q == OWNER_CPU);
        d_rvalid = rsp_pend_q && (rsp_owner_q == OWNER_DMA);
        c_err    = c_rvalid && rsp_err_q;
        d_err    = d_rvalid && rsp_err_q;
        c_rdata  = (c_rvalid && !rsp_err_q) ? mem_rdata : '0;
        d_rdata  = (d_rvalid && !rsp_err_q) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle grant/memory-drive checks plus a
// response scoreboard drained by an independent monitor.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
    logic [31:0] c_rdata, d_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [32:0] cq[$];
    logic [32:0] dq[$];

    logic [31:0] mem_model [0:255];
    logic        init_done = 1'b0;

    dmem_arbiter #(.ADDR_W(8), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory: write-then-read ordering, 1-cycle read latency.
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem_model[i] <= 32'hA500_0000 | 32'(i);
            init_done <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem_model[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_model[mem_addr];
        end
    end

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end else begin
            $display("ok   %s act=%h", name, act);
        end
    endtask

    // Response monitor: pops the oldest expectation for whichever port fires.
    always @(negedge clk) begin
        if (c_rvalid && d_rvalid) check("both_rvalid", 33'd1, 33'd0);
        if (c_rvalid) begin
            if (cq.size() == 0) check("c_unexpected_rsp", {c_err, c_rdata}, 33'h1_FFFF_FFFF);
            else                check("c_rsp", {c_err, c_rdata}, cq.pop_front());
        end
        if (d_rvalid) begin
            if (dq.size() == 0) check("d_unexpected_rsp", {d_err, d_rdata}, 33'h1_FFFF_FFFF);
            else                check("d_rsp", {d_err, d_rdata}, dq.pop_front());
        end
    end

    // One cycle: drive requests, check grants and memory drive, queue the
    // expected response of the expected winner.
    task automatic step(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cwd,
                        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                        input logic ec, input logic ed, input logic [31:0] erd, input string tag);
        logic [31:0] ea, ewd;
        logic        ew, mis, een;
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cwd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
        @(negedge clk);
        check({tag, "_gnt"}, {31'd0, c_gnt, d_gnt}, {31'd0, ec, ed});
        ea  = ed ? da : ca;
        ew  = ed ? dw : cw;
        ewd = ed ? dwd : cwd;
        mis = |ea[1:0];
        een = (ec | ed) && !mis;
        check({tag, "_en_we"}, {31'd0, mem_en, mem_we}, {31'd0, een, een & ew});
        if (een) check({tag, "_addr"}, {25'd0, mem_addr}, {25'd0, ea[9:2]});
        if (een && ew) check({tag, "_wdata"}, {1'b0, mem_wdata}, {1'b0, ewd});
        if ((ec | ed) && (!ew || mis)) begin
            if (ed) dq.push_back(mis ? 33'h1_0000_0000 : {1'b0, erd});
            else    cq.push_back(mis ? 33'h1_0000_0000 : {1'b0, erd});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {25'd0, c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err, mem_en, mem_we}, 33'd0);
        check("rst_rdata", {1'b0, c_rdata | d_rdata}, 33'd0);
        check("rst_mem", {1'b0, mem_wdata | {24'd0, mem_addr}}, 33'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Store then load of the same word in consecutive cycles.
        step(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, 0, "st10");
        step(1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, "ld10");
        // Misaligned load and store: error responses, memory untouched.
        step(1, 0, 32'h13, 0, 0, 0, 0, 0, 1, 0, 0, "mis_ld");
        step(1, 1, 32'h11, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 0, 0, "mis_st");
        step(0, 0, 0, 0, 1, 0, 32'h6, 0, 0, 1, 0, "d_mis_ld");
        step(1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, "ld10_again");
        idle("idle0");
        check("hold_addr", {25'd0, mem_addr}, 33'd4);

        // Back-to-back loads from different owners.
        step(1, 0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 32'hA500_0000, "c_ld0");
        step(0, 0, 0, 0, 1, 0, 32'h4, 0, 0, 1, 32'hA500_0001, "d_ld4");

        // Contention: four CPU wins, then the loader is forced through.
        for (int i = 0; i < 4; i++)
            step(1, 0, 32'h8, 0, 1, 0, 32'hC, 0, 1, 0, 32'hA500_0002, "cont_c");
        step(1, 0, 32'h8, 0, 1, 0, 32'hC, 0, 0, 1, 32'hA500_0003, "cont_d");
        step(1, 0, 32'h8, 0, 0, 0, 0, 0, 1, 0, 32'hA500_0002, "after_d");
        // Counter restarted after the loader grant and after a withdrawal.
        step(1, 0, 32'h8, 0, 1, 0, 32'hC, 0, 1, 0, 32'hA500_0002, "restart1");
        step(1, 0, 32'h8, 0, 1, 0, 32'hC, 0, 1, 0, 32'hA500_0002, "restart2");
        step(1, 0, 32'h8, 0, 0, 0, 0, 0, 1, 0, 32'hA500_0002, "withdraw");
        for (int i = 0; i < 4; i++)
            step(1, 0, 32'h8, 0, 1, 0, 32'hC, 0, 1, 0, 32'hA500_0002, "cont2_c");
        step(1, 0, 32'h8, 0, 1, 0, 32'hC, 0, 0, 1, 32'hA500_0003, "cont2_d");

        // Address wrap-around.
        step(0, 0, 0, 0, 1, 1, 32'h400, 32'h1234, 0, 1, 0, "wrap_st");
        step(1, 0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 32'h1234, "wrap_ld");
        idle("idle1");

        // Reset asserted in the middle of a granted load.
        c_req = 1; c_we = 0; c_addr = 32'h8;
        @(negedge clk);
        check("midrst_pre_gnt", {32'd0, c_gnt}, 33'd1);
        #2 reset = 1'b1;
        #1 check("midrst_outs", {26'd0, c_gnt, d_gnt, c_rvalid, d_rvalid, mem_en, mem_we, c_err}, 33'd0);
        @(negedge clk);
        check("midrst_no_rsp", {31'd0, c_rvalid, d_rvalid}, 33'd0);
        check("midrst_rdata", {1'b0, c_rdata}, 33'd0);
        c_req = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        step(1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, "post_rst_ld");
        idle("idle2");
        idle("idle3");

        check("c_queue_empty", 33'(cq.size()), 33'd0);
        check("d_queue_empty", 33'(dq.size()), 33'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
